// File: rtl/in_filter_cell.sv
// Input debounce filter with qualified-edge event flag and saturating event counter.
// FZ follows a stable input THRESH+2 cycles after it appears; EDGE/EVT/EVT_CNT update with FZ.
module in_filter_cell #(
  parameter int CNT_W = 4,
  parameter int EC_W  = 8
) (
  input  logic             IQC,
  input  logic             QRT,
  input  logic             IQZ_inp,
  input  logic             EN_inp,
  input  logic [CNT_W-1:0] THRESH_inp,
  input  logic [1:0]       EDGE_SEL_inp,
  input  logic             ACK_inp,
  input  logic             CLR_CNT_inp,
  output logic             FZ_out,
  output logic             EDGE_out,
  output logic             EVT_out,
  output logic [EC_W-1:0]  EVT_CNT_out
);

  logic             sample;
  logic [CNT_W-1:0] mis_cnt;
  logic             mismatch;
  logic             fire;
  logic             qual;
  logic             cnt_full;

  // >= rather than == so a threshold lowered below the running count fires at once;
  // the count only advances while below THRESH, so it can never wrap.
  always_comb begin
    mismatch = (sample != FZ_out);
    fire     = EN_inp && mismatch && (mis_cnt >= THRESH_inp);
    qual     = fire && (sample ? EDGE_SEL_inp[0] : EDGE_SEL_inp[1]);
    cnt_full = (EVT_CNT_out == {EC_W{1'b1}});
  end

  always_ff @(posedge IQC) begin
    if (QRT) begin
      sample      <= 1'b0;
      mis_cnt     <= '0;
      FZ_out      <= 1'b0;
      EDGE_out    <= 1'b0;
      EVT_out     <= 1'b0;
      EVT_CNT_out <= '0;
    end else begin
      sample <= IQZ_inp;

      if (!EN_inp || !mismatch || fire) begin
        mis_cnt <= '0;
      end else begin
        mis_cnt <= mis_cnt + CNT_W'(1);
      end

      if (fire) begin
        FZ_out <= sample;
      end

      EDGE_out <= qual;

      // A new event wins over a simultaneous acknowledge.
      if (qual) begin
        EVT_out <= 1'b1;
      end else if (ACK_inp) begin
        EVT_out <= 1'b0;
      end

      if (CLR_CNT_inp) begin
        EVT_CNT_out <= EC_W'(qual);
      end else if (qual && !cnt_full) begin
        EVT_CNT_out <= EVT_CNT_out + EC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_in_filter_cell.sv
// Self-checking bench for in_filter_cell: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the filter rules.
module tb_in_filter_cell;

  localparam int CNT_W = 4;
  localparam int EC_W  = 8;
  localparam int CMAX  = (1 << EC_W) - 1;

  logic             clk = 1'b0;
  logic             rst, iqz, en, ack, clr;
  logic [CNT_W-1:0] thresh;
  logic [1:0]       sel;
  logic             fz, edge_o, evt;
  logic [EC_W-1:0]  cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state: last sample, length of the current mismatch run,
  // filtered level, and the three event outputs.
  int m_s, m_run, m_fz, m_edge, m_evt, m_cnt;

  in_filter_cell #(.CNT_W(CNT_W), .EC_W(EC_W)) dut (
    .IQC          (clk),
    .QRT          (rst),
    .IQZ_inp      (iqz),
    .EN_inp       (en),
    .THRESH_inp   (thresh),
    .EDGE_SEL_inp (sel),
    .ACK_inp      (ack),
    .CLR_CNT_inp  (clr),
    .FZ_out       (fz),
    .EDGE_out     (edge_o),
    .EVT_out      (evt),
    .EVT_CNT_out  (cnt)
  );

  always #5 clk = ~clk;

  // Advance the model with the inputs about to be sampled, then clock the DUT.
  task automatic step();
    int new_fz;
    int qual;
    if (rst) begin
      m_s = 0; m_run = 0; m_fz = 0; m_edge = 0; m_evt = 0; m_cnt = 0;
    end else begin
      new_fz = m_fz;
      qual   = 0;
      if (en && m_s != m_fz) begin
        // The level flips on the (THRESH+1)-th consecutive disagreeing sample.
        if (m_run >= int'(thresh)) begin
          new_fz = m_s;
          m_run  = 0;
          qual   = (m_s == 1) ? int'(sel[0]) : int'(sel[1]);
        end else begin
          m_run = m_run + 1;
        end
      end else begin
        m_run = 0;
      end
      m_edge = qual;
      if (qual != 0) m_evt = 1;
      else if (ack) m_evt = 0;
      if (clr) m_cnt = qual;
      else if (qual != 0 && m_cnt < CMAX) m_cnt = m_cnt + 1;
      m_s  = int'(iqz);
      m_fz = new_fz;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic iqz_v);
    rst = 1'b1; iqz = iqz_v; en = 1'b1; ack = 1'b0; clr = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; iqz = 1'b1; en = 1'b1; thresh = '0; sel = 2'b11; ack = 1'b0; clr = 1'b0;
    repeat (3) step();
    checks++; if (fz !== 1'b0)     begin errors++; $display("FAIL reset_fz: got %b want 0", fz); end
    checks++; if (edge_o !== 1'b0) begin errors++; $display("FAIL reset_edge: got %b want 0", edge_o); end
    checks++; if (evt !== 1'b0)    begin errors++; $display("FAIL reset_evt: got %b want 0", evt); end
    checks++; if (cnt !== '0)      begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    rst = 1'b0;
  endtask

  task automatic test_debounce();
    do_reset(1'b0);
    thresh = 4'd3; sel = 2'b01;
    repeat (2) step();
    iqz = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      checks++;
      if (fz !== logic'(i >= 5)) begin errors++; $display("FAIL debounce_fz cyc%0d: got %b want %b", i, fz, i >= 5); end
      checks++;
      if (edge_o !== logic'(i == 5)) begin errors++; $display("FAIL debounce_edge cyc%0d: got %b want %b", i, edge_o, i == 5); end
    end
    checks++; if (evt !== 1'b1)   begin errors++; $display("FAIL debounce_evt: got %b want 1", evt); end
    checks++; if (cnt !== 8'd1)   begin errors++; $display("FAIL debounce_cnt: got %0d want 1", cnt); end
  endtask

  task automatic test_glitch();
    bit seen_fz = 0;
    bit seen_edge = 0;
    do_reset(1'b0);
    thresh = 4'd3; sel = 2'b11;
    repeat (2) step();
    iqz = 1'b1;
    repeat (3) begin step(); seen_fz |= fz; seen_edge |= edge_o; end
    iqz = 1'b0;
    repeat (8) begin step(); seen_fz |= fz; seen_edge |= edge_o; end
    checks++; if (seen_fz)      begin errors++; $display("FAIL glitch_fz: got 1 want 0"); end
    checks++; if (seen_edge)    begin errors++; $display("FAIL glitch_edge: got 1 want 0"); end
    checks++; if (cnt !== '0)   begin errors++; $display("FAIL glitch_cnt: got %0d want 0", cnt); end
  endtask

  task automatic test_thresh_lower();
    do_reset(1'b0);
    thresh = 4'd7; sel = 2'b01;
    repeat (2) step();
    iqz = 1'b1;
    repeat (5) step();
    checks++; if (fz !== 1'b0) begin errors++; $display("FAIL thresh_lower_before: got %b want 0", fz); end
    thresh = 4'd2;
    step();
    checks++; if (fz !== 1'b1) begin errors++; $display("FAIL thresh_lower_after: got %b want 1", fz); end
    checks++; if (edge_o !== 1'b1) begin errors++; $display("FAIL thresh_lower_edge: got %b want 1", edge_o); end
  endtask

  task automatic test_ack();
    do_reset(1'b0);
    thresh = '0; sel = 2'b11;
    iqz = 1'b1;
    repeat (2) step();
    checks++; if (evt !== 1'b1) begin errors++; $display("FAIL ack_setup_evt: got %b want 1", evt); end
    iqz = 1'b0;
    step();
    ack = 1'b1;
    step();
    checks++; if (edge_o !== 1'b1) begin errors++; $display("FAIL ack_coincident_edge: got %b want 1", edge_o); end
    checks++; if (evt !== 1'b1)    begin errors++; $display("FAIL ack_coincident_evt: got %b want 1", evt); end
    step();
    checks++; if (evt !== 1'b0)    begin errors++; $display("FAIL ack_alone_evt: got %b want 0", evt); end
    ack = 1'b0;
  endtask

  task automatic test_clr_cnt();
    do_reset(1'b0);
    thresh = '0; sel = 2'b11;
    repeat (7) begin iqz = ~iqz; repeat (3) step(); end
    checks++; if (cnt !== 8'd7) begin errors++; $display("FAIL clr_setup_cnt: got %0d want 7", cnt); end
    iqz = ~iqz;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (edge_o !== 1'b1) begin errors++; $display("FAIL clr_coincident_edge: got %b want 1", edge_o); end
    checks++; if (cnt !== 8'd1)    begin errors++; $display("FAIL clr_coincident_cnt: got %0d want 1", cnt); end
    step();
    checks++; if (cnt !== 8'd1)    begin errors++; $display("FAIL clr_hold_cnt: got %0d want 1", cnt); end
  endtask

  task automatic test_edge_sel();
    logic [1:0] sels [3] = '{2'b01, 2'b10, 2'b00};
    int exp_cnt = 0;
    do_reset(1'b0);
    thresh = 4'd1;
    for (int k = 0; k < 3; k++) begin
      sel = sels[k];
      iqz = 1'b1; repeat (4) step();
      if (sel[0]) exp_cnt++;
      checks++; if (cnt !== exp_cnt[EC_W-1:0]) begin errors++; $display("FAIL edge_sel_rise sel=%b: got %0d want %0d", sel, cnt, exp_cnt); end
      iqz = 1'b0; repeat (4) step();
      if (sel[1]) exp_cnt++;
      checks++; if (cnt !== exp_cnt[EC_W-1:0]) begin errors++; $display("FAIL edge_sel_fall sel=%b: got %0d want %0d", sel, cnt, exp_cnt); end
    end
  endtask

  task automatic test_saturate();
    int want;
    do_reset(1'b0);
    thresh = '0; sel = 2'b11;
    for (int k = 1; k <= 300; k++) begin
      iqz = ~iqz;
      repeat (4) step();
      want = (k < CMAX) ? k : CMAX;
      checks++;
      if (cnt !== want[EC_W-1:0]) begin errors++; $display("FAIL saturate_cnt toggle%0d: got %0d want %0d", k, cnt, want); end
    end
  endtask

  task automatic test_disable();
    do_reset(1'b0);
    thresh = '0; sel = 2'b11;
    iqz = 1'b1; repeat (2) step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin iqz = ~iqz; step(); end
    checks++; if (fz !== 1'b1)  begin errors++; $display("FAIL disable_fz_hold: got %b want 1", fz); end
    checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL disable_cnt_hold: got %0d want 1", cnt); end
    ack = 1'b1; step(); ack = 1'b0;
    checks++; if (evt !== 1'b0) begin errors++; $display("FAIL disable_ack: got %b want 0", evt); end
    clr = 1'b1; step(); clr = 1'b0;
    checks++; if (cnt !== '0)   begin errors++; $display("FAIL disable_clr: got %0d want 0", cnt); end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    do_reset(1'b0);
    thresh = 4'd5; sel = 2'b11;
    iqz = 1'b1; repeat (8) step();
    checks++; if (fz !== 1'b1) begin errors++; $display("FAIL reset_mid_setup_fz: got %b want 1", fz); end
    iqz = 1'b0; repeat (3) step();
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if ({fz, edge_o, evt, cnt} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: got fz=%b edge=%b evt=%b cnt=%0d want all 0", fz, edge_o, evt, cnt);
    end
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      iqz = ~iqz; step();
      if ({fz, edge_o, evt, cnt} !== '0) bad = 1;
    end
    checks++; if (bad) begin errors++; $display("FAIL reset_mid_disabled: got nonzero output want all 0"); end
    en = 1'b1;
  endtask

  task automatic test_release();
    rst = 1'b1; iqz = 1'b1; thresh = 4'd2; sel = 2'b01; en = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (fz !== logic'(i >= 4)) begin errors++; $display("FAIL release_fz cyc%0d: got %b want %b", i, fz, i >= 4); end
      checks++;
      if (edge_o !== logic'(i == 4)) begin errors++; $display("FAIL release_edge cyc%0d: got %b want %b", i, edge_o, i == 4); end
    end
    checks++; if (evt !== 1'b1) begin errors++; $display("FAIL release_evt: got %b want 1", evt); end
    checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL release_cnt: got %0d want 1", cnt); end
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) iqz = ~iqz;
      if ($urandom_range(0, 15) == 0) thresh = CNT_W'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) sel = 2'($urandom_range(0, 3));
      ack = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 31) == 0);
      step();
      checks++; if (fz !== logic'(m_fz))     begin errors++; $display("FAIL random_fz cyc%0d: got %b want %0d", i, fz, m_fz); end
      checks++; if (edge_o !== logic'(m_edge)) begin errors++; $display("FAIL random_edge cyc%0d: got %b want %0d", i, edge_o, m_edge); end
      checks++; if (evt !== logic'(m_evt))   begin errors++; $display("FAIL random_evt cyc%0d: got %b want %0d", i, evt, m_evt); end
      checks++; if (cnt !== m_cnt[EC_W-1:0]) begin errors++; $display("FAIL random_cnt cyc%0d: got %0d want %0d", i, cnt, m_cnt); end
    end
    rst = 1'b0; ack = 1'b0; clr = 1'b0; en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; iqz = 1'b0; en = 1'b0; ack = 1'b0; clr = 1'b0; thresh = '0; sel = 2'b00;
    m_s = 0; m_run = 0; m_fz = 0; m_edge = 0; m_evt = 0; m_cnt = 0;
    test_reset();
    test_debounce();
    test_glitch();
    test_thresh_lower();
    test_ack();
    test_clr_cnt();
    test_edge_sel();
    test_saturate();
    test_disable();
    test_reset_mid();
    test_release();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
